// File: rtl/qam_symbol_framer.sv
// Byte-to-symbol framer for the QAM mixer: buffers bytes in a small FIFO and emits
// preamble + payload 2-bit symbols, each held for SYM_PERIOD clocks.
module qam_symbol_framer #(
  parameter int         SYM_PERIOD   = 1000,
  parameter int         PREAMBLE_LEN = 8,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [1:0] IDLE_SYMBOL  = 2'b00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [1:0]                    sym_out,
  output logic                          sym_strobe,
  output logic                          frame_active,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(SYM_PERIOD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SYM_PERIOD - 1);
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;

  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [8:0]        head;
  logic              fifo_empty;
  logic              push, pop;

  logic [1:0]        sym_q, sym_d;
  logic              strobe_q;
  logic              underrun_q, underrun_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        pair_q, pair_d;
  logic [7:0]        sh_q, sh_d;
  logic              last_q, last_d;
  logic              fetch;

  // Symbol timing: everything symbol-related advances only on tick
  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Input FIFO; readiness comes from the registered level so a full FIFO
  // refuses a beat even on the cycle it pops
  assign fifo_empty = (level_q == '0);
  assign in_ready   = rst & (level_q < DEPTH_L);
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a failed fetch keeps the frame open in PAYLOAD
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: if (!fifo_empty)                   state_d = ST_PRE;
        ST_PRE:  if (pre_q == PRE_LAST)             state_d = ST_PAY;
        ST_PAY:  if ((pair_q == 2'd3) && last_q)    state_d = ST_IDLE;
        default:                                    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: symbol selection, preamble/pair counters and FIFO pop
  always_comb begin
    sym_d      = sym_q;
    pre_d      = pre_q;
    pair_d     = pair_q;
    sh_d       = sh_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    fetch      = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            sym_d = 2'b11;
            pre_d = PRE_W'(1);
          end else begin
            sym_d = IDLE_SYMBOL;
          end
        end
        ST_PRE: begin
          if (pre_q < PRE_LAST) begin
            sym_d = pre_q[0] ? 2'b00 : 2'b11;
            pre_d = pre_q + PRE_W'(1);
          end else begin
            fetch = 1'b1;
          end
        end
        ST_PAY: begin
          if (pair_q != 2'd3) begin
            sym_d  = sh_q[7:6];
            sh_d   = {sh_q[5:0], 2'b00};
            pair_d = pair_q + 2'd1;
          end else if (last_q) begin
            sym_d = IDLE_SYMBOL;
          end else begin
            fetch = 1'b1;
          end
        end
        default: sym_d = IDLE_SYMBOL;
      endcase
    end
    // Parking at pair 3 with last clear makes every later tick retry the fetch
    if (fetch) begin
      if (!fifo_empty) begin
        pop    = 1'b1;
        sym_d  = head[7:6];
        sh_d   = {head[5:0], 2'b00};
        last_d = head[8];
        pair_d = 2'd0;
      end else begin
        sym_d      = IDLE_SYMBOL;
        underrun_d = 1'b1;
        pair_d     = 2'd3;
        last_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_q      <= IDLE_SYMBOL;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      pre_q      <= '0;
      pair_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      sym_q      <= sym_d;
      strobe_q   <= tick;
      underrun_q <= underrun_d;
      pre_q      <= pre_d;
      pair_q     <= pair_d;
      last_q     <= last_d;
    end
  end

  assign sym_out      = sym_q;
  assign sym_strobe   = strobe_q;
  assign underrun     = underrun_q;
  assign frame_active = (state_q != ST_IDLE);
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_qam_symbol_framer.sv
// Randomized bench for qam_symbol_framer against a frame/queue level reference model.
module tb_qam_symbol_framer;

  localparam int P  = 8;
  localparam int PL = 4;
  localparam int FD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sym_out;
  logic       sym_strobe;
  logic       frame_active;
  logic       underrun;
  logic [2:0] fifo_level;

  qam_symbol_framer #(
    .SYM_PERIOD  (P),
    .PREAMBLE_LEN(PL),
    .FIFO_DEPTH  (FD),
    .IDLE_SYMBOL (2'b00)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sym_out     (sym_out),
    .sym_strobe  (sym_strobe),
    .frame_active(frame_active),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: symbols of the current frame are queued up front
  int         mcnt;
  bit         m_frame, m_end, m_pay, m_acc;
  logic [1:0] pend[$];
  logic [8:0] mfifo[$];
  logic [1:0] e_sym;
  bit         e_str, e_und;

  logic [1:0] seen[$];
  bit         prev_fa;
  int         und_cnt, cyc, acc_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcnt = 0; m_frame = 0; m_end = 0; m_pay = 0; m_acc = 0;
    pend.delete(); mfifo.delete();
    e_sym = 2'b00; e_str = 0; e_und = 0;
  endtask

  task automatic model_tick();
    logic [8:0] b;
    if (!m_frame) begin
      if (mfifo.size() != 0) begin
        m_frame = 1; m_end = 0; m_pay = 0;
        pend.delete();
        for (int i = 0; i < PL; i++) pend.push_back((i % 2 == 0) ? 2'b11 : 2'b00);
        e_sym = pend.pop_front();
      end else begin
        e_sym = 2'b00;
      end
    end else if (pend.size() != 0) begin
      e_sym = pend.pop_front();
    end else if (m_end) begin
      e_sym = 2'b00;
      m_frame = 0;
    end else if (mfifo.size() != 0) begin
      b = mfifo.pop_front();
      for (int k = 3; k >= 0; k--) pend.push_back(b[2*k+1 -: 2]);
      m_end = b[8];
      m_pay = 1;
      e_sym = pend.pop_front();
    end else begin
      e_sym = 2'b00;
      e_und = 1;
    end
  endtask

  task automatic model_step();
    bit tk;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_acc = in_valid && (mfifo.size() < FD);
      tk    = (mcnt == P - 1);
      e_str = tk;
      e_und = 0;
      if (tk) model_tick();
      if (m_acc) mfifo.push_back({in_last, in_data});
      mcnt = tk ? 0 : mcnt + 1;
    end
  endtask

  task automatic check_outputs();
    chk("sym_out", sym_out, e_sym);
    chk("sym_strobe", sym_strobe, e_str);
    chk("frame_active", frame_active, m_frame);
    chk("underrun", underrun, e_und);
    chk("fifo_level", fifo_level, mfifo.size());
    chk("in_ready", in_ready, (rst_n && mfifo.size() < FD) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    cyc++;
    if (underrun) und_cnt++;
    if (sym_strobe && (frame_active || prev_fa)) seen.push_back(sym_out);
    prev_fa = frame_active;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!m_acc && n < 500);
    if (!m_acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_frame || mfifo.size() != 0) && n < 3000) begin
      cycle();
      n++;
    end
    if (m_frame || mfifo.size() != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] exp_v, input int n);
    chk({tag, "_len"}, seen.size(), n);
    for (int i = 0; i < n; i++)
      if (i < seen.size()) chk(tag, seen[i], exp_v[2*(n-1-i) +: 2]);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sym"}, sym_out, 0);
    chk({tag, "_strobe"}, sym_strobe, 0);
    chk({tag, "_frame"}, frame_active, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  initial begin
    int first_str, n_str, n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    model_reset();
    prev_fa = 0; und_cnt = 0; cyc = 0;

    wait_cycles(3);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Idle: strobes every P cycles from release
    cyc = 0; first_str = -1; n_str = 0;
    for (int i = 0; i < 3 * P; i++) begin
      cycle();
      if (sym_strobe) begin
        n_str++;
        if (first_str < 0) first_str = cyc;
      end
    end
    chk("first_strobe_cycle", first_str, P);
    chk("strobe_count", n_str, 3);

    // Single byte frame
    seen.delete();
    send_byte(8'hB4, 1'b1);
    wait_idle();
    check_seq("b4", {2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, 9);

    // Two back-to-back bytes, no underrun
    wait_cycles(P);
    seen.delete(); und_cnt = 0;
    send_byte(8'hE4, 1'b0);
    send_byte(8'h1B, 1'b1);
    wait_idle();
    check_seq("e41b", {2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00,
                       2'b00, 2'b01, 2'b10, 2'b11, 2'b00}, 13);
    chk("e41b_no_underrun", und_cnt, 0);

    // Starved payload then late completion
    und_cnt = 0;
    send_byte(8'hFF, 1'b0);
    wait_cycles((PL + 4 + 3) * P);
    chk("ff_underrun_seen", (und_cnt >= 2) ? 1 : 0, 1);
    chk("ff_frame_held", frame_active, 1);
    send_byte(8'h55, 1'b1);
    seen.delete();
    wait_idle();
    check_seq("late55", {2'b01, 2'b01, 2'b01, 2'b01, 2'b00}, 5);

    // Backpressure: fill with no tick, then full-FIFO pop refuses the same-cycle beat
    n = 0;
    while (mcnt != 0 && n < 2 * P) begin cycle(); n++; end
    in_valid = 1'b1; in_last = 1'b1; in_data = 8'($urandom); acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (m_acc) begin acc_cnt++; in_data = 8'($urandom); end
    end
    chk("bp_accepted", acc_cnt, 4);
    chk("bp_level", fifo_level, 4);
    chk("bp_ready", in_ready, 0);
    n = 0;
    while (fifo_level == 3'd4 && n < 20 * P) begin
      cycle();
      if (m_acc) begin acc_cnt++; in_data = 8'($urandom); end
      n++;
    end
    chk("bp_pop_level", fifo_level, 3);
    chk("bp_refused_on_pop", acc_cnt, 4);
    cycle();
    if (m_acc) acc_cnt++;
    chk("bp_accept_next", acc_cnt, 5);
    chk("bp_refill_level", fifo_level, 4);
    in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a payload
    send_byte(8'h3C, 1'b1);
    send_byte(8'hA5, 1'b0);
    n = 0;
    while (!m_pay && n < 40 * P) begin cycle(); n++; end
    wait_cycles(3);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    prev_fa = 0;
    wait_cycles(3);
    rst_n = 1'b1;
    seen.delete();
    send_byte(8'h96, 1'b1);
    wait_idle();
    check_seq("after_rst", {2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00}, 9);

    // Random traffic with gaps long enough to starve payload
    for (int i = 0; i < 120; i++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 6);
      wait_cycles(n);
      send_byte(8'($urandom), ($urandom_range(0, 3) == 0));
    end
    in_last = 1'b1;
    send_byte(8'($urandom), 1'b1);
    wait_idle();
    wait_cycles(2 * P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_symbol_framer.md
Name: qam_symbol_framer

Overview:
- Upstream feeder for the QAM mixer.
- Accepts a byte stream with a valid/ready handshake and buffers it in a small FIFO.
- Emits framed 2-bit symbols, each held for exactly SYM_PERIOD clocks; every frame is a fixed alternating preamble followed by payload symbols.
- Replaces ad-hoc data sampling counters in front of the mixer, so symbol timing is deterministic and observable through sym_strobe.

Parameters:
SYM_PERIOD, 1000, clocks per symbol (>=2)
PREAMBLE_LEN, 8, preamble symbols per frame (even, >=2)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
IDLE_SYMBOL, 2'b00, symbol driven when no frame or payload is available

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
in_data  input  8  payload byte
in_last  input  1  byte is the final byte of its frame
in_valid  input  1  in_data/in_last valid
in_ready  output  1  FIFO can accept a beat
sym_out  output  2  current symbol to mixer data_in, registered
sym_strobe  output  1  one-cycle pulse in the first cycle of each new symbol
frame_active  output  1  high while preamble/payload symbols are on sym_out
underrun  output  1  one-cycle pulse when payload is needed but the FIFO is empty
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, async) sets:
  - sym_out=IDLE_SYMBOL, sym_strobe=0, frame_active=0, underrun=0, fifo_level=0.
  - Symbol counter=0, state=IDLE, FIFO empty.
  - in_ready=0 while rst low.
- Symbol counter:
  - Free-running 0..SYM_PERIOD-1, wraps to 0.
  - tick = (counter==SYM_PERIOD-1).
  - All symbol updates and FIFO pops occur only on tick; the updated sym_out and the sym_strobe pulse appear the next cycle.
  - First strobe occurs SYM_PERIOD cycles after reset release.
- FIFO:
  - Entries are 9 bits {last,data}.
  - in_ready = rst & (fifo_level < FIFO_DEPTH), computed from registered level.
  - Push when in_valid & in_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - When full, push is refused even if a pop occurs in the same cycle.
- State machine, evaluated on tick only:
  - IDLE:
    - FIFO non-empty -> PREAMBLE; emit 2'b11; pre_cnt=1; frame_active=1.
    - Otherwise emit IDLE_SYMBOL.
  - PREAMBLE:
    - pre_cnt<PREAMBLE_LEN -> emit alternating pattern (11,00,11,...); pre_cnt++.
    - pre_cnt==PREAMBLE_LEN -> PAYLOAD; apply the fetch rule.
  - PAYLOAD:
    - Shift register holds the current byte; pair_idx 0..3; emission order is bits[7:6],[5:4],[3:2],[1:0].
    - pair_idx<3 -> emit next pair.
    - pair_idx==3 and byte had last=1 -> IDLE; emit IDLE_SYMBOL; frame_active=0.
    - Otherwise apply the fetch rule.
  - Fetch rule:
    - FIFO non-empty -> pop head; emit data[7:6]; pair_idx=0.
    - FIFO empty -> emit IDLE_SYMBOL; pulse underrun; remain in PAYLOAD with frame_active=1.
    - The fetch is retried on every subsequent tick, and underrun pulses on each failed attempt.
- The last flag is latched with the popped byte; frame boundaries come only from in_last.
- A new frame begins with a full preamble again.
- An in_valid beat arriving on the same cycle as tick is not visible to that tick's fetch. The FIFO state used is the registered state before the push.
- Reset mid-frame discards FIFO contents and the partial byte. The next frame after release starts with a fresh preamble.
- sym_out changes only on cycles where sym_strobe=1; it is stable for exactly SYM_PERIOD cycles otherwise.

Test Plan:
- SYM_PERIOD=8, PREAMBLE_LEN=4, FIFO_DEPTH=4 for all tests.
- Reset release, no input -> sym_strobe pulses at cycles 8,16,24...; sym_out=00; frame_active=0; in_ready=1; fifo_level=0.
- Push single byte 0xB4 with last=1 -> sym_out sequence 11,00,11,00,10,11,01,00, then 00 with frame_active=0; fifo_level returns to 0 on the fetch tick.
- Push 0xE4 (last=0) then 0x1B (last=1) back-to-back -> preamble, then 11,10,01,00,00,01,10,11, then idle; no underrun pulse.
- Push 0xFF with last=0, then nothing -> after the 4 payload symbols, sym_out=00 with underrun pulsing every 8 cycles and frame_active=1. Later push 0x55 with last=1 -> at the next tick, emits 01,01,01,01 then idle.
- Hold in_valid high for 6 beats with no ticks -> exactly 4 beats accepted; in_ready=0 at fifo_level=4. On the pop tick with in_valid still high, the beat is refused that cycle and accepted the next.
- Assert rst low mid-payload for 3 cycles -> outputs immediately return to reset values; after release, a newly pushed byte produces a full 4-symbol preamble before payload.
